// File: rtl/sys_ctrl_pkg.sv
// Shared constants and types for the command-side system controller.
package sys_ctrl_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 4;
   localparam int unsigned FUNC_W = 4;

   localparam logic [7:0] CMD_RF_WR   = 8'hAA;
   localparam logic [7:0] CMD_RF_RD   = 8'hBB;
   localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
   localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

   localparam int unsigned ALU_OP_A_ADDR = 0;
   localparam int unsigned ALU_OP_B_ADDR = 1;

   typedef enum logic [3:0] {
      S_IDLE,
      S_WR_ADDR,
      S_WR_DATA,
      S_RD_ADDR,
      S_RD_WAIT,
      S_OP_A,
      S_OP_B,
      S_ALU_FN,
      S_ALU_WAIT,
      S_SEND
   } state_e;

endpackage

// File: rtl/sys_ctrl_rsp.sv
// Two-byte response buffer; pushes bytes into the TX FIFO whenever it is not full.
module sys_ctrl_rsp
   import sys_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [1:0]              load_cnt,
   input  logic [2*DATA_WIDTH-1:0] load_data,
   input  logic                    fifo_full,
   output logic [DATA_WIDTH-1:0]   tx_p_data,
   output logic                    tx_d_vld,
   output logic                    done_c
);

   logic [2*DATA_WIDTH-1:0] buf_q, buf_d;
   logic                    idx_q, idx_d;
   logic                    last_q, last_d;
   logic                    busy_q, busy_d;
   logic [DATA_WIDTH-1:0]   tx_p_data_q, tx_p_data_d;
   logic                    tx_d_vld_q, tx_d_vld_d;

   // Load on request and emit the next byte (LSB first) in any cycle the FIFO has room.
   always_comb begin
      buf_d       = buf_q;
      idx_d       = idx_q;
      last_d      = last_q;
      busy_d      = busy_q;
      tx_p_data_d = tx_p_data_q;
      tx_d_vld_d  = 1'b0;
      if (load) begin
         buf_d  = load_data;
         idx_d  = 1'b0;
         last_d = (load_cnt == 2'd2);
         busy_d = (load_cnt != 2'd0);
      end
      if (busy_d && !fifo_full) begin
         tx_d_vld_d  = 1'b1;
         tx_p_data_d = idx_d ? buf_d[2*DATA_WIDTH-1:DATA_WIDTH] : buf_d[DATA_WIDTH-1:0];
         if (idx_d == last_d) begin
            busy_d = 1'b0;
         end else begin
            idx_d = 1'b1;
         end
      end
   end

   // Response buffer and TX output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_q       <= '0;
         idx_q       <= 1'b0;
         last_q      <= 1'b0;
         busy_q      <= 1'b0;
         tx_p_data_q <= '0;
         tx_d_vld_q  <= 1'b0;
      end else begin
         buf_q       <= buf_d;
         idx_q       <= idx_d;
         last_q      <= last_d;
         busy_q      <= busy_d;
         tx_p_data_q <= tx_p_data_d;
         tx_d_vld_q  <= tx_d_vld_d;
      end
   end

   assign tx_p_data = tx_p_data_q;
   assign tx_d_vld  = tx_d_vld_q;
   assign done_c    = ~busy_q;

endmodule

// File: rtl/sys_ctrl.sv
// Command framer: parses RX bytes into RegFile and ALU operations and queues responses for UART TX.
module sys_ctrl
   import sys_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = DATA_W,
   parameter int unsigned ADDR_WIDTH     = ADDR_W,
   parameter int unsigned ALU_FUNC_WIDTH = FUNC_W
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic [DATA_WIDTH-1:0]       RX_P_DATA,
   input  logic                        RX_D_VLD,
   output logic [ADDR_WIDTH-1:0]       RF_ADDR,
   output logic                        RF_WR_EN,
   output logic [DATA_WIDTH-1:0]       RF_WR_DATA,
   output logic                        RF_RD_EN,
   input  logic [DATA_WIDTH-1:0]       RF_RD_DATA,
   input  logic                        RF_RD_DATA_VLD,
   output logic [ALU_FUNC_WIDTH-1:0]   ALU_FUNC,
   output logic                        ALU_EN,
   output logic                        ALU_CLK_EN,
   input  logic [2*DATA_WIDTH-1:0]     ALU_OUT,
   input  logic                        ALU_OUT_VALID,
   output logic [DATA_WIDTH-1:0]       TX_P_DATA,
   output logic                        TX_D_VLD,
   input  logic                        FIFO_FULL,
   output logic                        CMD_ERR
);

   localparam int unsigned RSP_W = 2 * DATA_WIDTH;

   state_e                      state_q, state_d;
   logic [ADDR_WIDTH-1:0]       rf_addr_q, rf_addr_d;
   logic                        rf_wr_en_q, rf_wr_en_d;
   logic [DATA_WIDTH-1:0]       rf_wr_data_q, rf_wr_data_d;
   logic                        rf_rd_en_q, rf_rd_en_d;
   logic [ALU_FUNC_WIDTH-1:0]   alu_func_q, alu_func_d;
   logic                        alu_en_q, alu_en_d;
   logic                        alu_clk_en_q, alu_clk_en_d;
   logic                        cmd_err_q, cmd_err_d;

   logic                        rsp_load_c;
   logic [1:0]                  rsp_cnt_c;
   logic [RSP_W-1:0]            rsp_data_c;
   logic                        rsp_done_c;

   // Next-state and registered-output logic; strobes default low, held values default to current.
   always_comb begin
      state_d      = state_q;
      rf_addr_d    = rf_addr_q;
      rf_wr_en_d   = 1'b0;
      rf_wr_data_d = rf_wr_data_q;
      rf_rd_en_d   = 1'b0;
      alu_func_d   = alu_func_q;
      alu_en_d     = alu_en_q;
      alu_clk_en_d = alu_clk_en_q;
      cmd_err_d    = 1'b0;
      rsp_load_c   = 1'b0;
      rsp_cnt_c    = 2'd0;
      rsp_data_c   = '0;
      case (state_q)
         S_IDLE: begin
            if (RX_D_VLD) begin
               case (RX_P_DATA)
                  DATA_WIDTH'(CMD_RF_WR):   state_d = S_WR_ADDR;
                  DATA_WIDTH'(CMD_RF_RD):   state_d = S_RD_ADDR;
                  DATA_WIDTH'(CMD_ALU_OP):  state_d = S_OP_A;
                  DATA_WIDTH'(CMD_ALU_NOP): state_d = S_ALU_FN;
                  default:                  cmd_err_d = 1'b1;
               endcase
            end
         end
         S_WR_ADDR: begin
            if (RX_D_VLD) begin
               rf_addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
               state_d   = S_WR_DATA;
            end
         end
         S_WR_DATA: begin
            if (RX_D_VLD) begin
               rf_wr_data_d = RX_P_DATA;
               rf_wr_en_d   = 1'b1;
               state_d      = S_IDLE;
            end
         end
         S_RD_ADDR: begin
            if (RX_D_VLD) begin
               rf_addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
               rf_rd_en_d = 1'b1;
               state_d    = S_RD_WAIT;
            end
         end
         S_RD_WAIT: begin
            if (RF_RD_DATA_VLD) begin
               rsp_load_c = 1'b1;
               rsp_cnt_c  = 2'd1;
               rsp_data_c = RSP_W'(RF_RD_DATA);
               state_d    = S_SEND;
            end
         end
         S_OP_A: begin
            if (RX_D_VLD) begin
               rf_addr_d    = ADDR_WIDTH'(ALU_OP_A_ADDR);
               rf_wr_data_d = RX_P_DATA;
               rf_wr_en_d   = 1'b1;
               state_d      = S_OP_B;
            end
         end
         S_OP_B: begin
            if (RX_D_VLD) begin
               rf_addr_d    = ADDR_WIDTH'(ALU_OP_B_ADDR);
               rf_wr_data_d = RX_P_DATA;
               rf_wr_en_d   = 1'b1;
               state_d      = S_ALU_FN;
            end
         end
         S_ALU_FN: begin
            if (RX_D_VLD) begin
               alu_func_d   = RX_P_DATA[ALU_FUNC_WIDTH-1:0];
               alu_en_d     = 1'b1;
               alu_clk_en_d = 1'b1;
               state_d      = S_ALU_WAIT;
            end
         end
         S_ALU_WAIT: begin
            if (ALU_OUT_VALID) begin
               rsp_load_c   = 1'b1;
               rsp_cnt_c    = 2'd2;
               rsp_data_c   = ALU_OUT;
               alu_en_d     = 1'b0;
               alu_clk_en_d = 1'b0;
               state_d      = S_SEND;
            end
         end
         S_SEND: begin
            if (rsp_done_c) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers; reset discards any partial command.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= S_IDLE;
         rf_addr_q    <= '0;
         rf_wr_en_q   <= 1'b0;
         rf_wr_data_q <= '0;
         rf_rd_en_q   <= 1'b0;
         alu_func_q   <= '0;
         alu_en_q     <= 1'b0;
         alu_clk_en_q <= 1'b0;
         cmd_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         rf_addr_q    <= rf_addr_d;
         rf_wr_en_q   <= rf_wr_en_d;
         rf_wr_data_q <= rf_wr_data_d;
         rf_rd_en_q   <= rf_rd_en_d;
         alu_func_q   <= alu_func_d;
         alu_en_q     <= alu_en_d;
         alu_clk_en_q <= alu_clk_en_d;
         cmd_err_q    <= cmd_err_d;
      end
   end

   sys_ctrl_rsp #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_rsp (
      .clk       (CLK),
      .rst       (RST),
      .load      (rsp_load_c),
      .load_cnt  (rsp_cnt_c),
      .load_data (rsp_data_c),
      .fifo_full (FIFO_FULL),
      .tx_p_data (TX_P_DATA),
      .tx_d_vld  (TX_D_VLD),
      .done_c    (rsp_done_c)
   );

   assign RF_ADDR    = rf_addr_q;
   assign RF_WR_EN   = rf_wr_en_q;
   assign RF_WR_DATA = rf_wr_data_q;
   assign RF_RD_EN   = rf_rd_en_q;
   assign ALU_FUNC   = alu_func_q;
   assign ALU_EN     = alu_en_q;
   assign ALU_CLK_EN = alu_clk_en_q;
   assign CMD_ERR    = cmd_err_q;

endmodule

// File: tb/tb_sys_ctrl.sv
// Scoreboard bench for sys_ctrl with RegFile, ALU and FIFO environment models.
module tb_sys_ctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic [7:0]  RX_P_DATA;
   logic        RX_D_VLD;
   logic [3:0]  RF_ADDR;
   logic        RF_WR_EN;
   logic [7:0]  RF_WR_DATA;
   logic        RF_RD_EN;
   logic [7:0]  RF_RD_DATA;
   logic        RF_RD_DATA_VLD;
   logic [3:0]  ALU_FUNC;
   logic        ALU_EN;
   logic        ALU_CLK_EN;
   logic [15:0] ALU_OUT;
   logic        ALU_OUT_VALID;
   logic [7:0]  TX_P_DATA;
   logic        TX_D_VLD;
   logic        FIFO_FULL;
   logic        CMD_ERR;

   logic rf_vld_r, alu_vld_r, spur_vld;
   assign RF_RD_DATA_VLD = rf_vld_r | spur_vld;
   assign ALU_OUT_VALID  = alu_vld_r | spur_vld;

   sys_ctrl dut (
      .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
      .RF_ADDR(RF_ADDR), .RF_WR_EN(RF_WR_EN), .RF_WR_DATA(RF_WR_DATA), .RF_RD_EN(RF_RD_EN),
      .RF_RD_DATA(RF_RD_DATA), .RF_RD_DATA_VLD(RF_RD_DATA_VLD),
      .ALU_FUNC(ALU_FUNC), .ALU_EN(ALU_EN), .ALU_CLK_EN(ALU_CLK_EN),
      .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID),
      .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .FIFO_FULL(FIFO_FULL), .CMD_ERR(CMD_ERR)
   );

   always #5 CLK = ~CLK;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic [11:0] exp_wr[$];
   logic [3:0]  exp_rd[$];
   logic [7:0]  exp_tx[$];
   logic [3:0]  exp_func[$];
   int          exp_err = 0;

   logic [7:0]  ref_rf[16];
   logic [7:0]  env_rf[16];

   bit          rand_full = 0;
   bit          force_full = 0;
   bit          bp_req = 0;
   bit          alu_ovr_en = 0;
   logic [15:0] alu_ovr_val = 16'h0;
   int          alu_delay_fixed = 0;
   logic        ff_sampled = 1'b0;

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Environment ALU: the DUT never computes this, it only carries the result back.
   function automatic logic [15:0] alu_calc(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
      case (f)
         4'd0:    return 16'(a) + 16'(b);
         4'd1:    return 16'(a) - 16'(b);
         4'd2:    return 16'(a) * 16'(b);
         4'd3:    return {a, b};
         default: return {f, 4'h0, a ^ b};
      endcase
   endfunction

   // FIFO_FULL seen by the DUT at each active edge.
   always @(posedge CLK) ff_sampled = FIFO_FULL;

   // FIFO full-flag driver.
   initial begin
      FIFO_FULL = 1'b0;
      forever begin
         @(posedge CLK);
         #2;
         FIFO_FULL = force_full || (rand_full && ($urandom_range(0, 3) == 0));
      end
   end

   // Monitor: pop the scoreboard whenever the DUT presents an output event.
   always @(negedge CLK) begin : mon
      logic [11:0] ew;
      if (!RST) begin
         if (RF_WR_EN) begin
            chk("rf_wr_expected", exp_wr.size() > 0, 1);
            if (exp_wr.size() > 0) begin
               ew = exp_wr.pop_front();
               chk("rf_wr_addr_data", {RF_ADDR, RF_WR_DATA}, ew);
            end
            env_rf[RF_ADDR] = RF_WR_DATA;
         end
         if (RF_RD_EN) begin
            chk("rf_rd_expected", exp_rd.size() > 0, 1);
            if (exp_rd.size() > 0) chk("rf_rd_addr", RF_ADDR, exp_rd.pop_front());
         end
         if (TX_D_VLD) begin
            chk("tx_while_full", ff_sampled, 0);
            chk("tx_expected", exp_tx.size() > 0, 1);
            if (exp_tx.size() > 0) chk("tx_byte", TX_P_DATA, exp_tx.pop_front());
         end
         if (CMD_ERR) begin
            chk("cmd_err_expected", exp_err > 0, 1);
            if (exp_err > 0) exp_err--;
         end
         chk("alu_clk_en_eq_en", ALU_CLK_EN, ALU_EN);
      end
   end

   // RegFile read responder.
   initial begin : rf_resp
      logic [3:0] a;
      rf_vld_r   = 1'b0;
      RF_RD_DATA = 8'h0;
      forever begin
         @(negedge CLK);
         if (!RST && RF_RD_EN) begin
            a = RF_ADDR;
            repeat ($urandom_range(0, 2)) @(posedge CLK);
            @(posedge CLK);
            #1;
            RF_RD_DATA = env_rf[a];
            rf_vld_r   = 1'b1;
            @(posedge CLK);
            #1;
            rf_vld_r   = 1'b0;
            RF_RD_DATA = 8'($urandom);
         end
      end
   end

   // ALU responder; also checks the enables across the wait.
   initial begin : alu_resp
      logic [3:0]  f;
      logic [15:0] res;
      int          d;
      alu_vld_r = 1'b0;
      ALU_OUT   = 16'h0;
      forever begin
         @(negedge CLK);
         if (!RST && ALU_EN) begin
            f = ALU_FUNC;
            chk("alu_func_expected", exp_func.size() > 0, 1);
            if (exp_func.size() > 0) chk("alu_func", f, exp_func.pop_front());
            res = alu_ovr_en ? alu_ovr_val : alu_calc(env_rf[0], env_rf[1], f);
            d = (alu_delay_fixed > 0) ? alu_delay_fixed : int'($urandom_range(0, 3));
            repeat (d) begin
               @(negedge CLK);
               chk("alu_en_hold", {ALU_EN, ALU_CLK_EN}, 2'b11);
            end
            if (bp_req) begin
               @(posedge CLK);
               #1 force_full = 1;
            end
            @(posedge CLK);
            #1;
            ALU_OUT   = res;
            alu_vld_r = 1'b1;
            @(posedge CLK);
            #1;
            alu_vld_r = 1'b0;
            @(negedge CLK);
            chk("alu_en_drop", {ALU_EN, ALU_CLK_EN}, 2'b00);
            if (!ff_sampled) chk("tx_latency", TX_D_VLD, 1);
            if (bp_req) begin
               repeat (4) @(posedge CLK);
               #1;
               force_full = 0;
               bp_req     = 0;
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      RX_P_DATA = b;
      RX_D_VLD  = 1'b1;
      @(posedge CLK);
      #1;
      RX_D_VLD  = 1'b0;
      RX_P_DATA = 8'($urandom);
      idle($urandom_range(0, 2));
   endtask

   task automatic rf_write(input logic [3:0] a, input logic [7:0] d);
      exp_wr.push_back({a, d});
      ref_rf[a] = d;
      send_byte(8'hAA);
      send_byte({4'($urandom), a});
      send_byte(d);
   endtask

   task automatic rf_read(input logic [3:0] a);
      exp_rd.push_back(a);
      exp_tx.push_back(ref_rf[a]);
      send_byte(8'hBB);
      send_byte({4'($urandom), a});
   endtask

   task automatic push_alu(input logic [3:0] f);
      logic [15:0] r;
      r = alu_calc(ref_rf[0], ref_rf[1], f);
      exp_func.push_back(f);
      exp_tx.push_back(r[7:0]);
      exp_tx.push_back(r[15:8]);
   endtask

   task automatic alu_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
      exp_wr.push_back({4'd0, a});
      exp_wr.push_back({4'd1, b});
      ref_rf[0] = a;
      ref_rf[1] = b;
      push_alu(f);
      send_byte(8'hCC);
      send_byte(a);
      send_byte(b);
      send_byte({4'($urandom), f});
   endtask

   task automatic alu_nop(input logic [3:0] f);
      push_alu(f);
      send_byte(8'hDD);
      send_byte({4'($urandom), f});
   endtask

   task automatic bad_op(input logic [7:0] b);
      exp_err++;
      send_byte(b);
   endtask

   task automatic drain();
      int t = 0;
      while ((exp_wr.size() != 0 || exp_rd.size() != 0 || exp_tx.size() != 0 ||
              exp_func.size() != 0 || exp_err != 0) && t < 300) begin
         @(posedge CLK);
         t++;
      end
      #1;
      chk("drain_in_time", t < 300, 1);
      idle(3);
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_rf_addr"}, RF_ADDR, 0);
      chk({tag, "_rf_wr_en"}, RF_WR_EN, 0);
      chk({tag, "_rf_wr_data"}, RF_WR_DATA, 0);
      chk({tag, "_rf_rd_en"}, RF_RD_EN, 0);
      chk({tag, "_alu_func"}, ALU_FUNC, 0);
      chk({tag, "_alu_en"}, ALU_EN, 0);
      chk({tag, "_alu_clk_en"}, ALU_CLK_EN, 0);
      chk({tag, "_tx_p_data"}, TX_P_DATA, 0);
      chk({tag, "_tx_d_vld"}, TX_D_VLD, 0);
      chk({tag, "_cmd_err"}, CMD_ERR, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [7:0] b;
      int         kind;
      RST       = 1'b1;
      RX_D_VLD  = 1'b0;
      RX_P_DATA = 8'h0;
      spur_vld  = 1'b0;
      for (int i = 0; i < 16; i++) begin
         b         = 8'($urandom);
         ref_rf[i] = b;
         env_rf[i] = b;
      end
      idle(2);
      check_outputs_zero("reset");
      RST = 1'b0;
      idle(1);

      // Directed: write, read back, ALU with operands.
      rf_write(4'd5, 8'h3C);
      drain();
      rf_read(4'd5);
      drain();
      alu_op(8'h0A, 8'h14, 4'd2);
      drain();

      // Backpressure on a no-operand ALU command with a fixed result.
      alu_ovr_en  = 1;
      alu_ovr_val = 16'h1234;
      bp_req      = 1;
      exp_func.push_back(4'd1);
      exp_tx.push_back(8'h34);
      exp_tx.push_back(8'h12);
      send_byte(8'hDD);
      send_byte(8'h01);
      drain();
      alu_ovr_en = 0;

      // Unknown opcode.
      bad_op(8'h55);
      drain();

      // Byte arriving during ALU_WAIT is dropped.
      alu_delay_fixed = 6;
      push_alu(4'd0);
      send_byte(8'hDD);
      RX_P_DATA = 8'h00;
      RX_D_VLD  = 1'b1;
      @(posedge CLK);
      #1;
      RX_D_VLD  = 1'b0;
      idle(2);
      RX_P_DATA = 8'h55;
      RX_D_VLD  = 1'b1;
      @(posedge CLK);
      #1;
      RX_D_VLD  = 1'b0;
      drain();
      alu_delay_fixed = 0;

      // Stray valid strobes while idle are ignored.
      spur_vld = 1'b1;
      idle(1);
      spur_vld = 1'b0;
      idle(3);
      drain();

      // Reset in the middle of a write frame.
      RX_P_DATA = 8'hAA;
      RX_D_VLD  = 1'b1;
      idle(1);
      RX_P_DATA = 8'h05;
      idle(1);
      RX_D_VLD  = 1'b0;
      chk("rf_addr_before_reset", RF_ADDR, 5);
      #1 RST = 1'b1;
      #1 check_outputs_zero("midrst");
      @(posedge CLK);
      #1 RST = 1'b0;
      idle(1);
      rf_write(4'd6, 8'h77);
      drain();
      rf_read(4'd6);
      drain();

      // Randomized command mix with random FIFO backpressure.
      rand_full = 1;
      repeat (60) begin
         kind = $urandom_range(0, 4);
         case (kind)
            0: rf_write(4'($urandom), 8'($urandom));
            1: rf_read(4'($urandom));
            2: alu_op(8'($urandom), 8'($urandom), 4'($urandom));
            3: alu_nop(4'($urandom));
            default: begin
               do b = 8'($urandom);
               while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD);
               bad_op(b);
            end
         endcase
         drain();
      end
      rand_full = 0;
      drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/sys_ctrl.md
Name: sys_ctrl

Overview:
- Command-side controller sitting between the UART RX path and the UART TX path in the REF_CLK domain.
- Consumes synchronized command bytes (post DATA_SYNC) and frames them into register-file read/write and ALU commands.
- Drives the RegFile, the ALU enable and its clock-gate enable.
- Writes response bytes into the async FIFO feeding UART TX, honouring FIFO_FULL backpressure.

Parameters:
- DATA_WIDTH, 8, width of command/response bytes and RegFile words.
- ADDR_WIDTH, 4, RegFile address width; taken from the low bits of the address byte.
- ALU_FUNC_WIDTH, 4, ALU function code width; taken from the low bits of the function byte.

Ports:
- CLK  in  1  REF_CLK domain clock.
- RST  in  1  asynchronous reset, active-high.
- RX_P_DATA  in  DATA_WIDTH  synchronized RX byte.
- RX_D_VLD  in  1  one-cycle pulse; RX_P_DATA valid.
- RF_ADDR  out  ADDR_WIDTH  RegFile address.
- RF_WR_EN  out  1  RegFile write strobe.
- RF_WR_DATA  out  DATA_WIDTH  RegFile write data.
- RF_RD_EN  out  1  RegFile read strobe.
- RF_RD_DATA  in  DATA_WIDTH  RegFile read data.
- RF_RD_DATA_VLD  in  1  RegFile read data valid.
- ALU_FUNC  out  ALU_FUNC_WIDTH  ALU operation select.
- ALU_EN  out  1  ALU enable.
- ALU_CLK_EN  out  1  clock-gate enable for ALU_CLK.
- ALU_OUT  in  2*DATA_WIDTH  ALU result.
- ALU_OUT_VALID  in  1  ALU result valid.
- TX_P_DATA  out  DATA_WIDTH  response byte to FIFO WR_DATA.
- TX_D_VLD  out  1  FIFO W_INC pulse.
- FIFO_FULL  in  1  FIFO full flag.
- CMD_ERR  out  1  one-cycle pulse on unknown opcode.

Behaviour:
- Reset: one clock; RST asynchronous, active-high. All outputs 0 on reset; FSM returns to IDLE; any in-flight command is discarded with no partial FIFO write.
- Opcodes (first byte of a frame):
  - 0xAA RF write: addr, data.
  - 0xBB RF read: addr.
  - 0xCC ALU with operands: A, B, func.
  - 0xDD ALU no operands: func.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FN, ALU_WAIT, SEND.
- Byte acceptance: a byte is accepted only on RX_D_VLD=1 in IDLE, WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, ALU_FN. RX_D_VLD in RD_WAIT, ALU_WAIT or SEND is ignored and the byte is dropped.
- IDLE: unknown opcode -> CMD_ERR pulse next cycle, remain IDLE.
- 0xAA:
  - Address byte is latched into RF_ADDR.
  - Data byte -> RF_WR_DATA=byte and RF_WR_EN=1 for exactly one cycle, the cycle after acceptance; then IDLE.
  - No response byte.
- 0xBB:
  - Address byte -> RF_RD_EN=1 for one cycle, then RD_WAIT.
  - On RF_RD_DATA_VLD, capture RF_RD_DATA into the response buffer (1 byte) and go to SEND.
- 0xCC:
  - Byte A -> RF write at address 0.
  - Byte B -> RF write at address 1.
  - Each write is a one-cycle RF_WR_EN, same timing as 0xAA.
  - Then ALU_FN.
- 0xDD: goes directly to ALU_FN.
- ALU_FN:
  - Function byte -> ALU_FUNC=byte[ALU_FUNC_WIDTH-1:0].
  - ALU_CLK_EN=1 and ALU_EN=1 from the next cycle; go to ALU_WAIT.
- ALU_WAIT:
  - Hold ALU_CLK_EN=1 and ALU_EN=1.
  - On ALU_OUT_VALID, capture ALU_OUT into a 2-byte buffer; deassert ALU_EN and ALU_CLK_EN the next cycle; go to SEND.
  - ALU_CLK_EN is 0 in every other state.
- SEND:
  - Emits buffered bytes in order; for ALU results, LSB first then MSB.
  - A byte is written (TX_P_DATA driven, TX_D_VLD=1 for one cycle) only in a cycle where FIFO_FULL=0.
  - While FIFO_FULL=1, stall with TX_D_VLD=0 and TX_P_DATA held.
  - Consecutive bytes may be written on back-to-back cycles.
  - After the last byte -> IDLE.
- Latency: command completion to first TX_D_VLD is 1 cycle when the FIFO is not full.
- Simultaneous events: RF_RD_DATA_VLD or ALU_OUT_VALID outside its wait state is ignored.

Decomposition:
- Shared package sys_ctrl_pkg holds:
  - Opcode constants CMD_RF_WR=8'hAA, CMD_RF_RD=8'hBB, CMD_ALU_OP=8'hCC, CMD_ALU_NOP=8'hDD.
  - FSM state enum.
  - ALU_OP_A_ADDR=0 and ALU_OP_B_ADDR=1.
- Sub-module sys_ctrl_rsp: a 2-byte response buffer and sequencer that performs the FIFO_FULL-gated writes. Interface: load, byte count (1/2), done.

Test Plan:
- RF write: bytes AA,05,3C -> one RF_WR_EN pulse with RF_ADDR=5, RF_WR_DATA=0x3C; no TX_D_VLD.
- RF read: bytes BB,05; RF returns 0x3C -> one RF_RD_EN with RF_ADDR=5; then one TX_D_VLD with TX_P_DATA=0x3C.
- ALU with operands: bytes CC,0A,14,02; ALU returns 0x00C8 -> RF writes (0,0x0A) and (1,0x14); ALU_FUNC=2; ALU_CLK_EN high through ALU_WAIT; TX bytes 0xC8 then 0x00.
- Backpressure: FIFO_FULL=1 for 5 cycles during SEND of DD,01 result 0x1234 -> no TX_D_VLD while full; then exactly 0x34, 0x12, no duplicates.
- Error/drop: byte 0x55 in IDLE -> CMD_ERR pulse, state IDLE. A byte arriving in ALU_WAIT is dropped and the response is unchanged.
- Reset mid-command: RST asserted after AA,05 -> all outputs 0 immediately; subsequent AA,06,77 writes address 6 correctly.
